// File: rtl/serial_adder_ctrl_if.sv
// rtl/serial_adder_ctrl_if.sv - operand/result and full-adder bundle for the bit-serial adder sequencer
interface serial_adder_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             c_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum_out;
  logic             c_out;
  logic             fa_a;
  logic             fa_b;
  logic             fa_cin;
  logic             fa_sum;
  logic             fa_carry;

  modport master (
    output start, a_in, b_in, c_in, fa_sum, fa_carry,
    input  busy, done, sum_out, c_out, fa_a, fa_b, fa_cin
  );

  modport slave (
    input  start, a_in, b_in, c_in, fa_sum, fa_carry,
    output busy, done, sum_out, c_out, fa_a, fa_b, fa_cin
  );
endinterface

// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - sequences an external single-bit full adder over WIDTH-bit operands, LSB first
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input logic                clk,
  input logic                rst,
  serial_adder_ctrl_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cy_q, cy_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy, done, fa_a, fa_b, fa_cin;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cy_q    <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cy_q    <= cy_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cy_d    = cy_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    busy    = 1'b0;
    done    = 1'b0;
    fa_a    = 1'b0;
    fa_b    = 1'b0;
    fa_cin  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_sh_d  = bus.a_in;
          b_sh_d  = bus.b_in;
          cy_d    = bus.c_in;
          cnt_d   = '0;
          res_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        busy   = 1'b1;
        fa_a   = a_sh_q[0];
        fa_b   = b_sh_q[0];
        fa_cin = cy_q;
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        res_d  = {bus.fa_sum, res_q[WIDTH-1:1]};
        cy_d   = bus.fa_carry;
        cnt_d  = cnt_q + CW'(1);
        // Final bit: the result register would only be complete one edge later, so commit from the live adder output.
        if (cnt_q == CW'(WIDTH - 1)) begin
          sum_d   = {bus.fa_sum, res_q[WIDTH-1:1]};
          cout_d  = bus.fa_carry;
          state_d = DONE;
        end
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy    = busy;
  assign bus.done    = done;
  assign bus.fa_a    = fa_a;
  assign bus.fa_b    = fa_b;
  assign bus.fa_cin  = fa_cin;
  assign bus.sum_out = sum_q;
  assign bus.c_out   = cout_q;
endmodule
